// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits one index per handshake in priority order.
// Latency: vector accepted at edge N, first index valid the cycle after; one index per cycle thereafter.
// Backpressure: o_idx/o_last/pending hold while o_idx_valid && !i_idx_ready; no new vector accepted until the last index drains.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req_valid/o_req_ready/i_req   request-vector handshake (8-bit multi-hot)
//   o_idx_valid/i_idx_ready/o_idx   index stream (3-bit), o_last marks the final set bit
//   o_busy             a captured vector is still being emitted
module encoder_8to3_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [7:0] i_req,
    output logic       o_idx_valid,
    input  logic       i_idx_ready,
    output logic [2:0] o_idx,
    output logic       o_last,
    output logic       o_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pending;
    logic [7:0] w_pending_nxt;

    logic [2:0] w_sel;
    logic [7:0] w_sel_onehot;
    logic       w_one_left;
    logic       w_emit;

    // Priority select over the pending mask. The loop visits candidates from
    // lowest to highest priority so the highest-priority set bit is written last.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (LSB_FIRST) begin
                if (r_pending[7-i]) w_sel = 3'(7 - i);
            end else begin
                if (r_pending[i]) w_sel = 3'(i);
            end
        end
    end

    assign w_sel_onehot = 8'd1 << w_sel;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_one_left = (r_pending != 8'd0) && ((r_pending & (r_pending - 8'd1)) == 8'd0);

    assign w_emit = (r_state == S_EMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pending <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            S_IDLE: begin
                // A zero vector is consumed by the handshake but produces nothing.
                if (i_req_valid && (i_req != 8'd0)) begin
                    w_pending_nxt = i_req;
                    w_state_nxt   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (i_idx_ready) begin
                    w_pending_nxt = r_pending & ~w_sel_onehot;
                    if (w_one_left) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = 8'd0;
            end
        endcase
    end

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        o_req_ready = ~w_emit;
        o_idx_valid = w_emit;
        o_busy      = w_emit;
        o_idx       = w_emit ? w_sel : 3'd0;
        o_last      = w_emit & w_one_left;
    end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req;
    logic       idx_ready;

    logic       req_ready,   m_req_ready;
    logic       idx_valid,   m_idx_valid;
    logic [2:0] idx,         m_idx;
    logic       last,        m_last;
    logic       busy,        m_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    encoder_8to3_seq #(.LSB_FIRST(1'b1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req       (req),
        .o_idx_valid (idx_valid),
        .i_idx_ready (idx_ready),
        .o_idx       (idx),
        .o_last      (last),
        .o_busy      (busy)
    );

    encoder_8to3_seq #(.LSB_FIRST(1'b0)) dut_msb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (m_req_ready),
        .i_req       (req),
        .o_idx_valid (m_idx_valid),
        .i_idx_ready (idx_ready),
        .o_idx       (m_idx),
        .o_last      (m_last),
        .o_busy      (m_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".valid"}, 32'(idx_valid), 32'd0);
        chk({tag, ".idx"},   32'(idx),       32'd0);
        chk({tag, ".last"},  32'(last),      32'd0);
        chk({tag, ".busy"},  32'(busy),      32'd0);
    endtask

    task automatic chk_beat(input string tag, input int exp_idx, input bit exp_last);
        chk({tag, ".valid"}, 32'(idx_valid), 32'd1);
        chk({tag, ".ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".busy"},  32'(busy),      32'd1);
        chk({tag, ".idx"},   32'(idx),       32'(exp_idx));
        chk({tag, ".last"},  32'(last),      32'(exp_last));
    endtask

    initial begin
        int lsb_seq[4];
        int msb_seq[4];
        lsb_seq = '{1, 2, 5, 7};
        msb_seq = '{7, 5, 2, 1};

        // Reset held with a live request that must not be captured.
        rst       = 1'b1;
        req_valid = 1'b1;
        req       = 8'hA5;
        idx_ready = 1'b0;
        step();
        chk_idle("rst0");
        step();
        chk_idle("rst1");
        chk("rst1.msb_valid", 32'(m_idx_valid), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        step();
        chk_idle("rst_rel");

        // One-hot sweep.
        for (int i = 0; i < 8; i++) begin
            req       = 8'd1 << i;
            req_valid = 1'b1;
            idx_ready = 1'b1;
            step();
            chk_beat($sformatf("onehot%0d", i), i, 1'b1);
            req_valid = 1'b0;
            step();
            chk($sformatf("onehot%0d.done_valid", i), 32'(idx_valid), 32'd0);
            chk($sformatf("onehot%0d.done_ready", i), 32'(req_ready), 32'd1);
        end

        // Multi-hot, both priority orders run in parallel.
        req       = 8'b1010_0110;
        req_valid = 1'b1;
        idx_ready = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("multi_lsb%0d", k), lsb_seq[k], k == 3);
            chk($sformatf("multi_msb%0d.valid", k), 32'(m_idx_valid), 32'd1);
            chk($sformatf("multi_msb%0d.idx", k),   32'(m_idx),       32'(msb_seq[k]));
            chk($sformatf("multi_msb%0d.last", k),  32'(m_last),      32'(k == 3));
            step();
        end
        chk_idle("multi_end");
        chk("multi_end.msb_ready", 32'(m_req_ready), 32'd1);

        // Backpressure, with req changed during EMIT.
        req       = 8'h81;
        req_valid = 1'b1;
        idx_ready = 1'b0;
        step();
        req_valid = 1'b0;
        req       = 8'h3C;
        for (int c = 0; c < 4; c++) begin
            chk_beat($sformatf("bp_hold%0d", c), 0, 1'b0);
            if (c == 3) idx_ready = 1'b1;
            step();
        end
        chk_beat("bp_last", 7, 1'b1);
        step();
        chk_idle("bp_end");

        // Zero vector then full vector.
        req       = 8'h00;
        req_valid = 1'b1;
        idx_ready = 1'b1;
        step();
        chk_idle("zero");
        req = 8'hFF;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_beat($sformatf("full%0d", k), k, k == 7);
            step();
        end
        chk_idle("full_end");

        // Reset in the middle of a vector.
        req       = 8'hF0;
        req_valid = 1'b1;
        idx_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk_beat("mid0", 4, 1'b0);
        step();
        chk_beat("mid1", 5, 1'b0);
        rst = 1'b1;
        step();
        chk_idle("mid_rst");
        rst = 1'b0;
        step();
        chk_idle("mid_after");
        step();
        chk_idle("mid_after2");
        req       = 8'h08;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk_beat("post_rst", 3, 1'b1);
        step();
        chk_idle("post_rst_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/encoder_8to3_seq.md
# encoder_8to3_seq

Sequential 8-to-3 encoder: the inverse of the 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake, then emits the 3-bit index of every set bit, one per handshake, in priority order. An upstream block hands over a multi-hot event mask; a downstream consumer receives a serialized stream of indices with a `last` marker.

## Interface
- `LSB_FIRST`, default 1: priority order. 1 emits lowest set index first; 0 emits highest first.
- `clk` input 1: rising-edge clock for all state.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request vector valid.
- `req_ready` output 1: block can accept a vector.
- `req` input 8: request vector, multi-hot allowed.
- `idx_valid` output 1: `idx` is valid.
- `idx_ready` input 1: consumer accepts `idx`.
- `idx` output 3: index of the current selected bit.
- `last` output 1: current `idx` is the final set bit of the captured vector.
- `busy` output 1: a vector is captured and not fully emitted.

## Operation
- Internal state: FSM {IDLE, EMIT}; 8-bit `pending` register.
- IDLE:
  - `req_ready`=1, `idx_valid`=0, `busy`=0.
  - On `req_valid` with `req`!=0: `pending`<=`req`, go to EMIT.
  - On `req_valid` with `req`==0: the vector is accepted and discarded. No output is produced and the FSM stays in IDLE.
- EMIT:
  - `req_ready`=0, `idx_valid`=1, `busy`=1.
  - `idx` is the priority-selected set bit of `pending`: lowest set bit if `LSB_FIRST`=1, highest if 0.
  - `last`=1 iff `pending` has exactly one bit set.
- Handshake:
  - `idx_valid && idx_ready` clears the selected bit in `pending`.
  - If `last` was 1, the FSM returns to IDLE on the same edge.
  - Otherwise it stays in EMIT and the next index is presented in the following cycle.
- `idx` and `last` are pure functions of `pending`, with no combinational path from any input. When `idx_valid`=0, `idx` and `last` read 0.
- `req` is sampled only on the accepting edge. Changes to `req` during EMIT are ignored.
- `rst` has priority over every transition: FSM to IDLE, `pending` to 0.

## Timing
- Reset values: `req_ready`=1 (IDLE), `idx_valid`=0, `idx`=0, `last`=0, `busy`=0.
- Latency: vector accepted at edge N; first index valid in the cycle after edge N.
- Throughput: one index per cycle while `idx_ready` is held high. A vector with k set bits takes k EMIT cycles.
- Back-to-back vectors: `req_ready` rises in the cycle after the `last` handshake, giving a minimum 1-cycle gap between vectors. A vector with k bits therefore occupies k+1 cycles, including the IDLE accept cycle.
- Backpressure: while `idx_valid`=1 and `idx_ready`=0, `idx`, `last` and `pending` hold stable for any number of cycles.
- `idx_ready` asserted while `idx_valid`=0 has no effect.
- Reset mid-EMIT: on the edge where `rst`=1, `pending` is lost and no further indices are emitted. The cycle after reset shows reset values.
- Boundaries:
  - `req`=8'hFF emits 0..7 (or 7..0) with `last` only on the 8th index.
  - A single-bit `req` emits one index with `last`=1.
  - The index-7 and index-0 extremes must encode as 3'd7 and 3'd0 with no wrap.

## Test plan
- Reset behaviour: hold `rst`=1 for 2 cycles with `req_valid`=1, `req`=8'hA5. Required: all outputs at reset values and no vector captured. Release reset: outputs stay at reset values with `req_ready`=1.
- One-hot sweep: apply `req`=1<<i for i=0..7 with `idx_ready`=1. Required: exactly one beat `idx`=i with `last`=1 for each vector, and `req_ready` low for one cycle per vector.
- Multi-hot, `LSB_FIRST`=1: `req`=8'b1010_0110 with `idx_ready`=1.
  - Required: `idx` sequence 1,2,5,7 on consecutive cycles, `last` only on 7.
  - With `LSB_FIRST`=0: sequence 7,5,2,1.
- Backpressure: `req`=8'h81, `idx_ready` low for 3 cycles, then high. Required: `idx`=0 held stable for 4 cycles, then `idx`=7 with `last`=1. `req` changed to 8'h3C during EMIT must be ignored.
- Zero vector plus full vector:
  - `req`=8'h00 accepted. Required: no `idx_valid`, and `req_ready` stays 1.
  - Then `req`=8'hFF. Required: indices 0..7 in 8 consecutive cycles, `last` on index 7, and `req_ready` back to 1 the following cycle.
- Reset mid-operation: `req`=8'hF0, assert `rst` after the second index (5) is accepted. Required: `idx_valid`=0 the next cycle and no index 6 or 7 emitted. A new vector `req`=8'h08 then yields a single `idx`=3 with `last`=1.
